// File: rtl/ysyx_24120009_lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the size-to-byte-count helper.
package ysyx_24120009_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/ysyx_24120009_lsu_lane.sv
// Byte-lane formatting for the LSU: store data/strobe placement by byte offset
// and load data extraction with sign or zero extension.
module ysyx_24120009_lsu_lane
    import ysyx_24120009_lsu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int OFF_W      = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]      off,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] wdata_lane,
    output logic [STRB_W-1:0]     wmask,
    output logic [DATA_WIDTH-1:0] rdata_ext
);

    logic [OFF_W+2:0]      bit_sh;
    logic [STRB_W-1:0]     base_mask;
    logic [DATA_WIDTH-1:0] rd_sh;
    logic signed [7:0]     ld_b;
    logic signed [15:0]    ld_h;
    logic signed [31:0]    ld_w;

    assign bit_sh     = {off, 3'b000};
    assign base_mask  = STRB_W'((32'd1 << size_bytes(size)) - 32'd1);
    assign wmask      = base_mask << off;
    assign wdata_lane = wdata << bit_sh;

    assign rd_sh = rdata >> bit_sh;
    assign ld_b  = rd_sh[7:0];
    assign ld_h  = rd_sh[15:0];
    assign ld_w  = rd_sh[31:0];

    // A full-width access falls through to the default and is passed unchanged.
    always_comb begin
        rdata_ext = rd_sh;
        case (size)
            SZ_B: begin
                if (is_unsigned) rdata_ext = DATA_WIDTH'(rd_sh[7:0]);
                else             rdata_ext = DATA_WIDTH'(ld_b);
            end
            SZ_H: begin
                if (is_unsigned) rdata_ext = DATA_WIDTH'(rd_sh[15:0]);
                else             rdata_ext = DATA_WIDTH'(ld_h);
            end
            SZ_W: begin
                if (is_unsigned) rdata_ext = DATA_WIDTH'(rd_sh[31:0]);
                else             rdata_ext = DATA_WIDTH'(ld_w);
            end
            default: rdata_ext = rd_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_24120009_lsu.sv
// Multi-cycle load/store unit with a valid/ready memory port, misalignment and
// bus-error reporting and a WAIT timeout. Define YSYX_24120009_LSU_PERF_EN to add perf counters.
module ysyx_24120009_lsu
    import ysyx_24120009_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_wen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
    input  logic                    mem_resp_err,
`ifdef YSYX_24120009_LSU_PERF_EN
    output logic [31:0]             perf_load_cnt,
    output logic [31:0]             perf_store_cnt,
    output logic [31:0]             perf_stall_cnt,
`endif
    output logic                    busy
);

    localparam int          STRB_W   = DATA_WIDTH / 8;
    localparam int          OFF_W    = $clog2(STRB_W);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    lsu_state_e state;
    logic       err_q;
    logic [31:0] tmo_cnt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [STRB_W-1:0]     wmask;
    logic [DATA_WIDTH-1:0] rdata_ext;

    logic [2:0] align_mask;
    logic       size_illegal;
    logic       misaligned;
    logic       req_bad;

    assign align_mask   = 3'(size_bytes(req_size) - 4'd1);
    assign size_illegal = (DATA_WIDTH == 32) && (req_size == SZ_D);
    assign misaligned   = |(req_addr[2:0] & align_mask);
    assign req_bad      = size_illegal | misaligned;

    ysyx_24120009_lsu_lane #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
        .off        (addr_q[OFF_W-1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .wdata      (wdata_q),
        .rdata      (mem_resp_rdata),
        .wdata_lane (wdata_lane),
        .wmask      (wmask),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        err_q <= req_bad;
                        state <= req_bad ? RESP : REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        tmo_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        err_q <= mem_resp_err;
                        state <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; every output using them is gated by state.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (state == WAIT && mem_resp_valid && !wen_q) begin
            rdata_q <= rdata_ext;
        end
    end

    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_req_wen   = mem_req_valid & wen_q;
    assign mem_req_addr  = mem_req_valid ? (addr_q & ~ADDR_WIDTH'(STRB_W - 1)) : '0;
    assign mem_req_wdata = mem_req_valid ? wdata_lane : '0;
    assign mem_req_wmask = mem_req_valid ? wmask : '0;
    assign resp_valid    = (state == RESP);
    assign resp_err      = resp_valid & err_q;
    assign resp_rdata    = resp_valid ? rdata_q : '0;

`ifdef YSYX_24120009_LSU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_cnt  <= '0;
            perf_store_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (state == RESP && resp_ready && !err_q) begin
                if (wen_q && perf_store_cnt != '1) perf_store_cnt <= perf_store_cnt + 32'd1;
                if (!wen_q && perf_load_cnt != '1) perf_load_cnt <= perf_load_cnt + 32'd1;
            end
            if ((state == REQ || state == WAIT) && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24120009_lsu.sv
// Scoreboard bench for the LSU: a 32-bit instance with a 4-cycle timeout and a
// 64-bit instance with the default timeout share one stimulus bus selected by sel.
module tb_ysyx_24120009_lsu;
    import ysyx_24120009_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        req_valid, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready, mem_req_ready, mem_resp_valid, mem_resp_err;
    logic [63:0] mem_resp_rdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req_valid, a_mem_req_wen, a_busy;
    logic [31:0] a_resp_rdata, a_mem_req_addr, a_mem_req_wdata;
    logic [3:0]  a_mem_req_wmask;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req_valid, b_mem_req_wen, b_busy;
    logic [63:0] b_resp_rdata, b_mem_req_wdata;
    logic [31:0] b_mem_req_addr;
    logic [7:0]  b_mem_req_wmask;
`ifdef YSYX_24120009_LSU_PERF_EN
    logic [31:0] a_perf_ld, a_perf_st, a_perf_stall, b_perf_ld, b_perf_st, b_perf_stall;
`endif

    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_req_wen, o_busy;
    logic [63:0] o_resp_rdata, o_mem_req_wdata;
    logic [31:0] o_mem_req_addr;
    logic [7:0]  o_mem_req_wmask;

    ysyx_24120009_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 0), .req_ready(a_req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(a_mem_req_wen),
        .mem_req_addr(a_mem_req_addr), .mem_req_wdata(a_mem_req_wdata), .mem_req_wmask(a_mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata[31:0]),
        .mem_resp_err(mem_resp_err),
`ifdef YSYX_24120009_LSU_PERF_EN
        .perf_load_cnt(a_perf_ld), .perf_store_cnt(a_perf_st), .perf_stall_cnt(a_perf_stall),
`endif
        .busy(a_busy)
    );

    ysyx_24120009_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 1), .req_ready(b_req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(b_mem_req_wen),
        .mem_req_addr(b_mem_req_addr), .mem_req_wdata(b_mem_req_wdata), .mem_req_wmask(b_mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err(mem_resp_err),
`ifdef YSYX_24120009_LSU_PERF_EN
        .perf_load_cnt(b_perf_ld), .perf_store_cnt(b_perf_st), .perf_stall_cnt(b_perf_stall),
`endif
        .busy(b_busy)
    );

    always_comb begin
        if (sel == 1) begin
            o_req_ready = b_req_ready;   o_resp_valid = b_resp_valid; o_resp_err = b_resp_err;
            o_mem_req_valid = b_mem_req_valid; o_mem_req_wen = b_mem_req_wen; o_busy = b_busy;
            o_resp_rdata = b_resp_rdata; o_mem_req_wdata = b_mem_req_wdata;
            o_mem_req_addr = b_mem_req_addr; o_mem_req_wmask = b_mem_req_wmask;
        end else begin
            o_req_ready = a_req_ready;   o_resp_valid = a_resp_valid; o_resp_err = a_resp_err;
            o_mem_req_valid = a_mem_req_valid; o_mem_req_wen = a_mem_req_wen; o_busy = a_busy;
            o_resp_rdata = {32'b0, a_resp_rdata}; o_mem_req_wdata = {32'b0, a_mem_req_wdata};
            o_mem_req_addr = a_mem_req_addr; o_mem_req_wmask = {4'b0, a_mem_req_wmask};
        end
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request through the selected DUT; x_lat == 1 means an error-only response.
    task automatic txn(input string tag, input int s, input logic wen, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] mrd, input logic merr,
                       input int rq_stall, input int rs_delay, input int rp_stall,
                       input logic [31:0] x_maddr, input logic [63:0] x_wdata, input logic [7:0] x_mask,
                       input logic [63:0] x_rdata, input logic x_err, input int x_lat);
        exp_t e;
        int   lat;
        int   k;
        sel = s;
        req_wen = wen; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        e.rdata = x_rdata;
        e.err   = x_err;
        sb.push_back(e);
        #1;
        check({tag, ".req_ready"}, o_req_ready, 1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        if (x_lat == 1) begin
            check({tag, ".no_mem"}, o_mem_req_valid, 0);
        end else begin
            for (int i = 0; i <= rq_stall; i++) begin
                check({tag, ".mreq_valid"}, o_mem_req_valid, 1);
                check({tag, ".mreq_addr"}, o_mem_req_addr, x_maddr);
                check({tag, ".mreq_wen"}, o_mem_req_wen, wen);
                if (wen) begin
                    check({tag, ".mreq_wdata"}, o_mem_req_wdata, x_wdata);
                    check({tag, ".mreq_wmask"}, o_mem_req_wmask, x_mask);
                end
                check({tag, ".busy_req"}, {o_req_ready, o_busy}, 2'b01);
                mem_req_ready = (i == rq_stall);
                tick();
                lat++;
            end
            mem_req_ready = 1'b0;
            k = 0;
            while (!o_resp_valid && k < 300) begin
                if (k == 0) check({tag, ".mreq_drop"}, o_mem_req_valid, 0);
                if (k == rs_delay) begin
                    mem_resp_valid = 1'b1; mem_resp_rdata = mrd; mem_resp_err = merr;
                end
                tick();
                lat++;
                k++;
                mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
            end
        end
        check({tag, ".resp_valid"}, o_resp_valid, 1);
        check({tag, ".latency"}, lat, x_lat);
        if (sb.size() != 0) e = sb.pop_front();
        for (int i = 0; i <= rp_stall; i++) begin
            check({tag, ".rdata"}, o_resp_rdata, e.rdata);
            check({tag, ".err"}, o_resp_err, e.err);
            check({tag, ".req_ready_resp"}, o_req_ready, 0);
            resp_ready = (i == rp_stall);
            tick();
        end
        resp_ready = 1'b0;
        check({tag, ".done"}, {o_resp_valid, o_req_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sel = 0;
        req_valid = 0; req_wen = 0; req_size = SZ_B; req_unsigned = 0; req_addr = '0; req_wdata = '0;
        resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0; mem_resp_rdata = '0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("rst.req_ready", o_req_ready, 1);
            check("rst.busy", o_busy, 0);
            check("rst.resp", {o_resp_valid, o_resp_err, o_resp_rdata}, '0);
            check("rst.mreq", {o_mem_req_valid, o_mem_req_wen, o_mem_req_addr, o_mem_req_wmask}, '0);
            check("rst.mreq_wdata", o_mem_req_wdata, '0);
        end
        rst = 1'b0;
        tick();

        // 32-bit data path
        txn("lb_s", 0, 0, SZ_B, 0, 32'h8000_0003, 64'h0, 64'h8011_2233, 0, 0, 0, 0,
            32'h8000_0000, 64'h0, 8'h0, 64'hFFFF_FF80, 0, 3);
        txn("sh", 0, 1, SZ_H, 0, 32'h8000_0002, 64'h0000_BEEF, 64'h1234_5678, 0, 0, 0, 0,
            32'h8000_0000, 64'hBEEF_0000, 8'h0C, 64'h0, 0, 3);
        txn("lw_mis", 0, 0, SZ_W, 0, 32'h8000_0002, 64'h0, 64'h0, 0, 0, 0, 0,
            32'h0, 64'h0, 8'h0, 64'h0, 1, 1);
        txn("sd_illegal32", 0, 1, SZ_D, 0, 32'h8000_0008, 64'h55, 64'h0, 0, 0, 0, 1,
            32'h0, 64'h0, 8'h0, 64'h0, 1, 1);
        txn("lw_buserr", 0, 0, SZ_W, 0, 32'h8000_0004, 64'h0, 64'hDEAD_BEEF, 1, 0, 2, 0,
            32'h8000_0004, 64'h0, 8'h0, 64'hDEAD_BEEF, 1, 5);
        txn("lw_timeout", 0, 0, SZ_W, 0, 32'h8000_0010, 64'h0, 64'h0, 0, 0, -1, 0,
            32'h8000_0010, 64'h0, 8'h0, 64'h0, 1, 6);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_FFFF;
        tick();
        mem_resp_valid = 1'b0;
        check("idle_resp_ignored", {o_resp_valid, o_busy, o_req_ready}, 3'b001);
        txn("lhu_after_to", 0, 0, SZ_H, 1, 32'h8000_0012, 64'h0, 64'hF00D_1234, 0, 0, 0, 0,
            32'h8000_0010, 64'h0, 8'h0, 64'h0000_F00D, 0, 3);

        // 64-bit data path
        txn("lh_stall", 1, 0, SZ_H, 0, 32'h8000_0006, 64'h0, 64'h8001_2345_6789_ABCD, 0, 5, 7, 2,
            32'h8000_0000, 64'h0, 8'h0, 64'hFFFF_FFFF_FFFF_8001, 0, 15);
        txn("lwu64", 1, 0, SZ_W, 1, 32'h8000_0004, 64'h0, 64'hF000_0000_0000_0000, 0, 0, 0, 0,
            32'h8000_0000, 64'h0, 8'h0, 64'h0000_0000_F000_0000, 0, 3);
        txn("lw64_s", 1, 0, SZ_W, 0, 32'h8000_0004, 64'h0, 64'hF000_0000_0000_0000, 0, 0, 0, 0,
            32'h8000_0000, 64'h0, 8'h0, 64'hFFFF_FFFF_F000_0000, 0, 3);
        txn("sb64", 1, 1, SZ_B, 0, 32'h8000_0005, 64'hAB, 64'h0, 0, 0, 0, 0,
            32'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20, 64'h0, 0, 3);
        txn("sd64", 1, 1, SZ_D, 0, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 0, 1, 1, 0,
            32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 0, 5);
        txn("ld_mis64", 1, 0, SZ_D, 0, 32'h8000_000C, 64'h0, 64'h0, 0, 0, 0, 0,
            32'h0, 64'h0, 8'h0, 64'h0, 1, 1);

        // reset while waiting on memory
        sel = 1;
        req_wen = 0; req_size = SZ_W; req_unsigned = 0; req_addr = 32'h8000_0000; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        check("wait.busy", {o_busy, o_req_ready}, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wait.ctrl", {o_busy, o_req_ready, o_mem_req_valid, o_resp_valid}, 4'b0100);
        check("rst_wait.data", o_resp_rdata, '0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234;
        tick();
        mem_resp_valid = 1'b0;
        check("rst_wait.late_resp", {o_resp_valid, o_busy}, 2'b00);
        txn("ld64_after_rst", 1, 0, SZ_D, 0, 32'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0,
            32'h8000_0010, 64'h0, 8'h0, 64'h0123_4567_89AB_CDEF, 0, 3);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
